// File: rtl/priority_decoder.sv
// priority_decoder: registered 2-to-4 one-hot decoder with enable priority,
// optional input synchroniser (PRIORITYDECODER_SYNC_EN) and change strobe.
// Ports: clk, rst_n (async active-low), en, a (MSB), b (LSB) in;
//        d0..d3 one-hot out, vld (registered enable), chg (change pulse).
module priority_decoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic vld,
  output logic chg
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be 2..4");
  end

  logic en_s;
  logic a_s;
  logic b_s;

`ifdef PRIORITYDECODER_SYNC_EN
  // en, a and b share one chain depth so they stay aligned.
  logic [SYNC_STAGES-1:0] en_sh;
  logic [SYNC_STAGES-1:0] a_sh;
  logic [SYNC_STAGES-1:0] b_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sh <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
    end else begin
      en_sh <= {en_sh[SYNC_STAGES-2:0], en};
      a_sh  <= {a_sh[SYNC_STAGES-2:0], a};
      b_sh  <= {b_sh[SYNC_STAGES-2:0], b};
    end
  end

  assign en_s = en_sh[SYNC_STAGES-1];
  assign a_s  = a_sh[SYNC_STAGES-1];
  assign b_s  = b_sh[SYNC_STAGES-1];
`else
  assign en_s = en;
  assign a_s  = a;
  assign b_s  = b;
`endif

  logic [3:0] nxt;
  logic [3:0] q;

  // Enable wins over the code: disabled means all-zero.
  always_comb begin
    nxt = 4'b0000;
    if (en_s) begin
      unique case ({a_s, b_s})
        2'b00:   nxt = 4'b0001;
        2'b01:   nxt = 4'b0010;
        2'b10:   nxt = 4'b0100;
        2'b11:   nxt = 4'b1000;
        default: nxt = 4'b0000;
      endcase
    end
  end

  // q doubles as the history register: chg compares the
  // value being loaded against the one currently held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 4'b0000;
      vld <= 1'b0;
      chg <= 1'b0;
    end else begin
      q   <= nxt;
      vld <= en_s;
      chg <= (nxt != q);
    end
  end

  assign d0 = q[0];
  assign d1 = q[1];
  assign d2 = q[2];
  assign d3 = q[3];

endmodule

// File: tb/tb_priority_decoder.sv
// tb_priority_decoder: randomized and directed checks of priority_decoder
// against a delay-queue reference model.
module tb_priority_decoder;

  localparam int SS = 2;
`ifdef PRIORITYDECODER_SYNC_EN
  localparam int LAT = SS + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic en, a, b;
  logic d0, d1, d2, d3, vld, chg;

  int errs = 0;
  int checks = 0;

  priority_decoder #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .vld(vld), .chg(chg)
  );

  always #5 clk = ~clk;

  logic [2:0] pipe[$];
  logic [3:0] exp_d;
  logic [3:0] prev_d;
  logic exp_v, exp_c;
  int chg_cnt;

  task automatic chk(input string tag,
                     input logic [5:0] got,
                     input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s t=%0t got vld,chg,d3..d0=%b want %b",
               tag, $time, got, want);
    end
  endtask

  task automatic mreset();
    pipe.delete();
    for (int i = 0; i < LAT - 1; i++) pipe.push_back(3'b000);
    exp_d = 4'b0000;
    exp_v = 1'b0;
    exp_c = 1'b0;
  endtask

  function automatic logic [5:0] outs();
    return {vld, chg, d3, d2, d1, d0};
  endfunction

  // One clock: model samples the same inputs the DUT sees, then compare.
  task automatic step(input string tag);
    logic [2:0] cur, x;
    @(posedge clk);
    cur = {en, a, b};
    if (LAT == 1) x = cur;
    else begin
      x = pipe.pop_front();
      pipe.push_back(cur);
    end
    prev_d = exp_d;
    exp_v  = x[2];
    exp_d  = x[2] ? 4'(1 << x[1:0]) : 4'd0;
    exp_c  = (exp_d != prev_d);
    #1;
    if (chg) chg_cnt++;
    chk(tag, outs(), {exp_v, exp_c, exp_d});
  endtask

  task automatic hold(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    // Reset visible with no clock edge, inputs all high.
    rst_n = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1;
    #2;
    chk("reset_async", outs(), 6'b000000);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep all codes with enable held.
    en = 1'b1;
    chg_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      {a, b} = 2'(c);
      hold("sweep", 10);
    end
    checks++;
    if (chg_cnt != 4) begin
      errs++;
      $display("FAIL sweep_chg_count got %0d want 4", chg_cnt);
    end

    // Enable priority then re-enable on code 10.
    {a, b} = 2'b10;
    hold("code10", LAT + 2);
    en = 1'b0;
    hold("disable", LAT + 3);
    en = 1'b1;
    hold("reenable", LAT + 3);

    // Simultaneous enable and code change.
    en = 1'b0; {a, b} = 2'b01;
    hold("simul_off", LAT + 2);
    en = 1'b1; {a, b} = 2'b11;
    hold("simul_on", LAT + 2);

    // Random traffic, inputs held 1..4 cycles.
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(0, 4) != 0);
      a  = 1'($urandom);
      b  = 1'($urandom);
      hold("rand", $urandom_range(1, 4));
    end

    // Mid-operation reset with d3 high, between edges.
    en = 1'b1; {a, b} = 2'b11;
    hold("pre_rst", LAT + 2);
    chk("d3_before_rst", outs(), {1'b1, 1'b0, 4'b1000});
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_mid", outs(), 6'b000000);
    mreset();
    {a, b} = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    hold("post_rst", LAT + 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
